watch_set_ctrl: RTL and testbench
=================================

# watch_set_ctrl

Time-setting controller that sequences the `counter` block. In normal operation it lets the counter run. On a mode request it freezes counting, snapshots the current time into shadow registers, and walks the user through hours, minutes and seconds with up/down adjustment. It then commits the result through a single-cycle load pulse. It sits between the debounced button logic and `counter`, and drives `count_enable_i`, `load_time_i` and the `load_*_i` values of `counter`.

## Interface
- `TIMEOUT_S`, default 30: seconds without any button pulse in a set state before the edit is aborted (range 1..63).
- `clk_100MHz_i`  in  1  system clock, 100 MHz.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `seconds_pulse_i`  in  1  one-cycle pulse, once per second.
- `btn_mode_i`  in  1  one-cycle debounced pulse: enter set / next field / commit.
- `btn_up_i`  in  1  one-cycle debounced pulse: increment the selected field.
- `btn_down_i`  in  1  one-cycle debounced pulse: decrement the selected field.
- `seconds_i`  in  6  current seconds from `counter` (0..59).
- `minutes_i`  in  6  current minutes from `counter` (0..59).
- `hours_i`  in  5  current hours from `counter` (0..23).
- `count_enable_o`  out  1  to `counter.count_enable_i`.
- `load_time_o`  out  1  to `counter.load_time_i`; one-cycle pulse.
- `load_seconds_o`  out  6  shadow seconds.
- `load_minutes_o`  out  6  shadow minutes.
- `load_hours_o`  out  5  shadow hours.
- `edit_field_o`  out  2  field under edit: 0 none, 1 hours, 2 minutes, 3 seconds.
- `blink_o`  out  1  display blink phase for the edited field.

## Operation
- FSM states: RUN, SET_H, SET_M, SET_S, COMMIT.
- RUN:
  - `count_enable_o` = 1, `edit_field_o` = 0, `blink_o` = 0.
  - On `btn_mode_i`: capture `hours_i`/`minutes_i`/`seconds_i` into the shadow registers, clear the timeout counter, and go to SET_H.
- SET_H / SET_M / SET_S:
  - `count_enable_o` = 0. `edit_field_o` = 1 / 2 / 3.
  - `btn_up_i` adds 1 to the selected shadow field, with wrap: hours 23→0, minutes and seconds 59→0.
  - `btn_down_i` subtracts 1 with wrap: 0→23 for hours, 0→59 for minutes and seconds.
  - `btn_mode_i`: SET_H→SET_M, SET_M→SET_S, SET_S→COMMIT.
- Priority within one cycle: `btn_mode_i` over up/down. While mode is pulsing, up/down are ignored.
- Up and down in the same cycle: no change to the field. This still counts as activity.
- Any button pulse clears the timeout counter.
- Timeout:
  - Each `seconds_pulse_i` in a set state with no button pulse that cycle increments the timeout counter.
  - When it reaches `TIMEOUT_S`, go to RUN without loading; shadow values are discarded.
- `blink_o` toggles on each `seconds_pulse_i` in set states. It is forced to 0 on entry to SET_H and in RUN.
- COMMIT: `load_time_o` = 1 and `count_enable_o` = 0 for exactly one cycle, then RUN unconditionally. Buttons are ignored in COMMIT.
- `load_*_o` always show the shadow registers. They are meaningful only while `load_time_o` = 1.

## Timing
- Reset (`reset_n_i` low, asynchronous):
  - State RUN; shadows 0; timeout counter 0.
  - `count_enable_o` = 1, `load_time_o` = 0, `edit_field_o` = 0, `blink_o` = 0.
- Reset asserted mid-edit: return to RUN immediately with no load pulse.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- Mode pulse at cycle N in RUN:
  - Shadow equals the inputs sampled at N.
  - `count_enable_o` falls at N+1 and `edit_field_o` = 1 at N+1.
  - A `seconds_pulse_i` at N is still counted by `counter`. The snapshot misses that increment; this is accepted.
- Up/down at cycle N: the updated shadow is visible at N+1.
- Mode at cycle N in SET_S:
  - `load_time_o` is high during N+1.
  - RUN with `count_enable_o` = 1 at N+2.
- Timeout on the seconds pulse at cycle N: RUN at N+1, no `load_time_o`.

## Structure
- Package `watch_pkg` holds:
  - `state_t` enum (RUN, SET_H, SET_M, SET_S, COMMIT).
  - `field_t` encoding for `edit_field_o`.
  - Constants `MAX_HOURS` = 23, `MAX_MINSEC` = 59, and the widths 5 and 6.
  - Shared with `counter` and the display block.
- Sub-module `wrap_step`, parameterised on width and max value.
  - Inputs: value, up, down. Output: next value with wrap.
  - Instantiated three times.

## Test plan
- Reset low mid-SET_M → outputs at reset values with no clock edge needed; `count_enable_o` = 1, `load_time_o` never pulses.
- Time 12:34:56 → sequence: mode, down ×13, mode, up ×26, mode, up ×4, mode → one `load_time_o` pulse with 23:00:00, then `count_enable_o` = 1 on the following cycle.
- Same-cycle events:
  - In SET_H at hours 5, up and down together → hours stays 5 and the timeout counter is cleared.
  - Mode and up together → go to SET_M with hours unchanged.
- With `TIMEOUT_S` = 3, enter SET_H and apply 3 seconds pulses with no buttons → RUN, no load pulse, counter values untouched, `blink_o` = 0.
- With `seconds_pulse_i` and mode both at cycle N while the counter is at 00:00:59 → shadow = 00:00:59, the counter advances to 00:01:00, then freezes.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch datapath: time fields, edit-field
// encoding and the set-mode controller state.
package watch_pkg;

  localparam int unsigned HOURS_W    = 5;
  localparam int unsigned MINSEC_W   = 6;
  localparam int unsigned TMO_W      = 6;
  localparam int unsigned MAX_HOURS  = 23;
  localparam int unsigned MAX_MINSEC = 59;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FIELD_NONE    = 2'd0,
    FIELD_HOURS   = 2'd1,
    FIELD_MINUTES = 2'd2,
    FIELD_SECONDS = 2'd3
  } field_t;

  typedef struct packed {
    logic [HOURS_W-1:0]  hours;
    logic [MINSEC_W-1:0] minutes;
    logic [MINSEC_W-1:0] seconds;
  } time_t;

  // Field shown as "under edit" for a given controller state.
  function automatic field_t field_of(input state_t st);
    case (st)
      SET_H:   return FIELD_HOURS;
      SET_M:   return FIELD_MINUTES;
      SET_S:   return FIELD_SECONDS;
      default: return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wrap_step.sv
// Combinational +1/-1 stepper over the range 0..MAX with wrap-around.
// Up and down together leave the value unchanged.
module wrap_step #(
  parameter int unsigned W   = 6,
  parameter int unsigned MAX = 59
) (
  input  logic [W-1:0] value_i,
  input  logic         up_i,
  input  logic         down_i,
  output logic [W-1:0] step_c_o
);

  always_comb begin
    step_c_o = value_i;
    if (up_i && !down_i) begin
      step_c_o = (value_i >= W'(MAX)) ? '0 : value_i + W'(1);
    end else if (down_i && !up_i) begin
      step_c_o = (value_i == '0) ? W'(MAX) : value_i - W'(1);
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting controller: freezes the counter, edits a shadow copy of the
// time field by field, and commits it with a one-cycle load pulse.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic                clk_100MHz_i,
  input  logic                reset_n_i,
  input  logic                seconds_pulse_i,
  input  logic                btn_mode_i,
  input  logic                btn_up_i,
  input  logic                btn_down_i,
  input  logic [MINSEC_W-1:0] seconds_i,
  input  logic [MINSEC_W-1:0] minutes_i,
  input  logic [HOURS_W-1:0]  hours_i,
  output logic                count_enable_o,
  output logic                load_time_o,
  output logic [MINSEC_W-1:0] load_seconds_o,
  output logic [MINSEC_W-1:0] load_minutes_o,
  output logic [HOURS_W-1:0]  load_hours_o,
  output logic [1:0]          edit_field_o,
  output logic                blink_o
);

  state_t             state_q, state_d;
  time_t              shadow_q, shadow_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               blink_q, blink_d;
  logic               cen_q, cen_d;
  logic               load_q, load_d;
  field_t             field_q, field_d;

  logic [HOURS_W-1:0]  hours_step_c;
  logic [MINSEC_W-1:0] minutes_step_c;
  logic [MINSEC_W-1:0] seconds_step_c;
  logic                adjust_c;
  logic                in_set_c;

  assign adjust_c = btn_up_i | btn_down_i;
  assign in_set_c = (state_q == SET_H) || (state_q == SET_M) || (state_q == SET_S);

  wrap_step #(.W(HOURS_W), .MAX(MAX_HOURS)) u_step_hours (
    .value_i  (shadow_q.hours),
    .up_i     (btn_up_i),
    .down_i   (btn_down_i),
    .step_c_o (hours_step_c)
  );

  wrap_step #(.W(MINSEC_W), .MAX(MAX_MINSEC)) u_step_minutes (
    .value_i  (shadow_q.minutes),
    .up_i     (btn_up_i),
    .down_i   (btn_down_i),
    .step_c_o (minutes_step_c)
  );

  wrap_step #(.W(MINSEC_W), .MAX(MAX_MINSEC)) u_step_seconds (
    .value_i  (shadow_q.seconds),
    .up_i     (btn_up_i),
    .down_i   (btn_down_i),
    .step_c_o (seconds_step_c)
  );

  // Next-state, shadow, timeout and blink computation.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    tmo_d    = tmo_q;
    blink_d  = blink_q;

    case (state_q)
      RUN: begin
        blink_d = 1'b0;
        if (btn_mode_i) begin
          shadow_d.hours   = hours_i;
          shadow_d.minutes = minutes_i;
          shadow_d.seconds = seconds_i;
          tmo_d            = '0;
          state_d          = SET_H;
        end
      end
      SET_H, SET_M, SET_S: begin
        if (seconds_pulse_i) begin
          blink_d = ~blink_q;
        end
        // Mode wins over up/down; any button restarts the inactivity timer.
        if (btn_mode_i) begin
          tmo_d = '0;
          if (state_q == SET_H) begin
            state_d = SET_M;
          end else if (state_q == SET_M) begin
            state_d = SET_S;
          end else begin
            state_d = COMMIT;
          end
        end else if (adjust_c) begin
          tmo_d = '0;
          if (state_q == SET_H) begin
            shadow_d.hours = hours_step_c;
          end else if (state_q == SET_M) begin
            shadow_d.minutes = minutes_step_c;
          end else begin
            shadow_d.seconds = seconds_step_c;
          end
        end else if (seconds_pulse_i) begin
          if (tmo_q >= TMO_W'(TIMEOUT_S - 1)) begin
            tmo_d   = '0;
            state_d = RUN;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      COMMIT: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!((state_d == SET_H) || (state_d == SET_M) || (state_d == SET_S))) begin
      blink_d = 1'b0;
    end else if (!in_set_c) begin
      blink_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    cen_d   = (state_d == RUN);
    load_d  = (state_d == COMMIT);
    field_d = field_of(state_d);
  end

  always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= RUN;
      shadow_q <= '0;
      tmo_q    <= '0;
      blink_q  <= 1'b0;
      cen_q    <= 1'b1;
      load_q   <= 1'b0;
      field_q  <= FIELD_NONE;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      tmo_q    <= tmo_d;
      blink_q  <= blink_d;
      cen_q    <= cen_d;
      load_q   <= load_d;
      field_q  <= field_d;
    end
  end

  assign count_enable_o = cen_q;
  assign load_time_o    = load_q;
  assign load_hours_o   = shadow_q.hours;
  assign load_minutes_o = shadow_q.minutes;
  assign load_seconds_o = shadow_q.seconds;
  assign edit_field_o   = field_q;
  assign blink_o        = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl with a behavioural counter model and
// a scoreboard of expected committed times.
module tb_watch_set_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sec_pulse;
  logic       btn_mode, btn_up, btn_down;
  logic [5:0] cnt_s, cnt_m;
  logic [4:0] cnt_h;
  logic       cen, load;
  logic [5:0] ld_s, ld_m;
  logic [4:0] ld_h;
  logic [1:0] field;
  logic       blink;

  logic       preset_req;
  logic [4:0] pre_h;
  logic [5:0] pre_m, pre_s;

  int total = 0;
  int bad   = 0;
  int load_cnt = 0;

  typedef struct {
    int h;
    int m;
    int s;
  } exp_time_t;
  exp_time_t exp_q[$];

  watch_set_ctrl #(.TIMEOUT_S(3)) dut (
    .clk_100MHz_i    (clk),
    .reset_n_i       (rst_n),
    .seconds_pulse_i (sec_pulse),
    .btn_mode_i      (btn_mode),
    .btn_up_i        (btn_up),
    .btn_down_i      (btn_down),
    .seconds_i       (cnt_s),
    .minutes_i       (cnt_m),
    .hours_i         (cnt_h),
    .count_enable_o  (cen),
    .load_time_o     (load),
    .load_seconds_o  (ld_s),
    .load_minutes_o  (ld_m),
    .load_hours_o    (ld_h),
    .edit_field_o    (field),
    .blink_o         (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the counter block.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h <= '0; cnt_m <= '0; cnt_s <= '0;
    end else if (preset_req) begin
      cnt_h <= pre_h; cnt_m <= pre_m; cnt_s <= pre_s;
    end else if (load) begin
      cnt_h <= ld_h; cnt_m <= ld_m; cnt_s <= ld_s;
    end else if (cen && sec_pulse) begin
      if (cnt_s == 6'd59) begin
        cnt_s <= '0;
        if (cnt_m == 6'd59) begin
          cnt_m <= '0;
          cnt_h <= (cnt_h == 5'd23) ? 5'd0 : cnt_h + 5'd1;
        end else begin
          cnt_m <= cnt_m + 6'd1;
        end
      end else begin
        cnt_s <= cnt_s + 6'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Every load pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n && load === 1'b1) begin
      load_cnt++;
      if (exp_q.size() == 0) begin
        chk("load_unexpected", 32'd1, 32'd0);
      end else begin
        exp_time_t e;
        e = exp_q.pop_front();
        chk("load_h", 32'(ld_h), 32'(e.h));
        chk("load_m", 32'(ld_m), 32'(e.m));
        chk("load_s", 32'(ld_s), 32'(e.s));
      end
    end
  end

  task automatic step(input logic m, input logic u, input logic d, input logic s);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d; sec_pulse = s;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic preset(input int h, input int m, input int s);
    @(negedge clk);
    pre_h = 5'(h); pre_m = 6'(m); pre_s = 6'(s); preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
  endtask

  task automatic push_exp(input int h, input int m, input int s);
    exp_time_t e;
    e.h = h; e.m = m; e.s = s;
    exp_q.push_back(e);
  endtask

  initial begin
    int loads_before;
    rst_n = 1'b0; sec_pulse = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    preset_req = 0; pre_h = '0; pre_m = '0; pre_s = '0;
    #12;
    chk("rst_cen", 32'(cen), 32'd1);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_field", 32'(field), 32'd0);
    chk("rst_blink", 32'(blink), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Full edit of 12:34:56 to 23:00:00.
    preset(12, 34, 56);
    step(1, 0, 0, 0); idle();
    chk("ent_field", 32'(field), 32'd1);
    chk("ent_cen", 32'(cen), 32'd0);
    chk("ent_shadow_h", 32'(ld_h), 32'd12);
    for (int i = 0; i < 13; i++) step(0, 0, 1, 0);
    idle();
    chk("h_down13", 32'(ld_h), 32'd23);
    step(1, 0, 0, 0); idle();
    chk("field_m", 32'(field), 32'd2);
    for (int i = 0; i < 26; i++) step(0, 1, 0, 0);
    idle();
    chk("m_up26", 32'(ld_m), 32'd0);
    step(1, 0, 0, 0); idle();
    chk("field_s", 32'(field), 32'd3);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    idle();
    chk("s_up4", 32'(ld_s), 32'd0);
    push_exp(23, 0, 0);
    step(1, 0, 0, 0); idle();
    chk("commit_load", 32'(load), 32'd1);
    chk("commit_cen", 32'(cen), 32'd0);
    idle();
    chk("after_commit_cen", 32'(cen), 32'd1);
    chk("after_commit_load", 32'(load), 32'd0);
    chk("counter_loaded", 32'({cnt_h, cnt_m, cnt_s}), 32'({5'd23, 6'd0, 6'd0}));

    // Up+down together counts as activity; mode beats up.
    preset(5, 10, 20);
    step(1, 0, 0, 0); idle();
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 1, 1, 0);
    step(0, 0, 0, 1); step(0, 0, 0, 1); idle();
    chk("updn_field", 32'(field), 32'd1);
    chk("updn_hours", 32'(ld_h), 32'd5);
    step(1, 1, 0, 0); idle();
    chk("modeup_field", 32'(field), 32'd2);
    chk("modeup_hours", 32'(ld_h), 32'd5);
    loads_before = load_cnt;
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1); idle();
    chk("tmo_m_field", 32'(field), 32'd0);
    chk("tmo_m_cen", 32'(cen), 32'd1);

    // Timeout from SET_H with blink tracking.
    preset(7, 8, 9);
    step(1, 0, 0, 0); idle();
    chk("blink_entry", 32'(blink), 32'd0);
    step(0, 0, 0, 1); idle();
    chk("blink_toggle", 32'(blink), 32'd1);
    chk("tmo_not_yet", 32'(field), 32'd1);
    step(0, 0, 0, 1); idle();
    chk("blink_toggle2", 32'(blink), 32'd0);
    step(0, 0, 0, 1); idle();
    chk("tmo_h_field", 32'(field), 32'd0);
    chk("tmo_h_cen", 32'(cen), 32'd1);
    chk("tmo_h_blink", 32'(blink), 32'd0);
    chk("tmo_no_load", 32'(load_cnt), 32'(loads_before));
    chk("tmo_cnt_kept", 32'({cnt_h, cnt_m, cnt_s}), 32'({5'd7, 6'd8, 6'd9}));

    // Seconds pulse coinciding with mode at 00:00:59.
    preset(0, 0, 59);
    step(1, 0, 0, 1); idle();
    chk("snap_field", 32'(field), 32'd1);
    chk("snap_shadow", 32'({ld_h, ld_m, ld_s}), 32'({5'd0, 6'd0, 6'd59}));
    chk("snap_counter", 32'({cnt_h, cnt_m, cnt_s}), 32'({5'd0, 6'd1, 6'd0}));
    step(0, 0, 0, 1); idle();
    chk("frozen_counter", 32'({cnt_h, cnt_m, cnt_s}), 32'({5'd0, 6'd1, 6'd0}));
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    push_exp(0, 0, 59);
    step(1, 0, 0, 0); idle(); idle();
    chk("snap_commit_cen", 32'(cen), 32'd1);

    // Asynchronous reset while in SET_M.
    preset(9, 9, 9);
    step(1, 0, 0, 0); step(1, 0, 0, 0); idle();
    chk("pre_rst_field", 32'(field), 32'd2);
    loads_before = load_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cen", 32'(cen), 32'd1);
    chk("arst_field", 32'(field), 32'd0);
    chk("arst_load", 32'(load), 32'd0);
    chk("arst_shadow", 32'({ld_h, ld_m, ld_s}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); idle(); idle();
    chk("arst_no_load", 32'(load_cnt), 32'(loads_before));
    chk("arst_run_cen", 32'(cen), 32'd1);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("load_total", 32'(load_cnt), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
